// File: rtl/clock_pkg.sv
// Shared state codes, field-select codes and default timing for the clock set-mode controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_e;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HOUR = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_SEC  = 2'd3;

    localparam int DEF_BLINK_TICKS   = 50;
    localparam int DEF_TIMEOUT_TICKS = 1000;

    function automatic logic [1:0] sel_code(input state_e st);
        case (st)
            SET_HOUR: sel_code = SEL_HOUR;
            SET_MIN:  sel_code = SEL_MIN;
            SET_SEC:  sel_code = SEL_SEC;
            default:  sel_code = SEL_NONE;
        endcase
    endfunction

    function automatic state_e next_field(input state_e st);
        case (st)
            SET_HOUR: next_field = SET_MIN;
            SET_MIN:  next_field = SET_SEC;
            default:  next_field = SET_HOUR;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_blink.sv
// Blink generator: counts 100 Hz ticks while enabled and toggles o_blink every BLINK_TICKS ticks.
module clock_set_blink
    import clock_pkg::*;
#(
    parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_tick,
    input  logic i_clr,
    output logic o_blink
);

    localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;

    // A clear or leaving the set states shows the field immediately.
    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (i_clr || !i_en) begin
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (i_tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign o_blink = blink_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode controller for the 24-h clock: freezes counting, selects a field and pulses its increment.
// Optional auto-exit to RUN after idle ticks is enabled by defining CLOCK_SET_CTRL_AUTO_EXIT_EN.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_TICKS   = DEF_BLINK_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick_100hz,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    output logic       o_run,
    output logic       o_clr_msec,
    output logic       o_inc_hour,
    output logic       o_inc_min,
    output logic       o_inc_sec,
    output logic [1:0] o_sel,
    output logic       o_blink
);

    state_e     state_q, state_d;
    logic       run_q, run_d;
    logic [1:0] sel_q, sel_d;
    logic       clr_msec_q, clr_msec_d;
    logic       inc_hour_q, inc_hour_d;
    logic       inc_min_q, inc_min_d;
    logic       inc_sec_q, inc_sec_d;
    logic       blink_clr;
    logic       timeout_expire;

`ifdef CLOCK_SET_CTRL_AUTO_EXIT_EN
    localparam int TO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            any_btn;

    // A button pressed on the expiring tick counts as activity and wins.
    always_comb begin
        any_btn  = btn_mode | btn_next | btn_up;
        to_cnt_d = to_cnt_q;
        if (state_q == RUN || any_btn) begin
            to_cnt_d = '0;
        end else if (i_tick_100hz) begin
            to_cnt_d = (to_cnt_q == TO_LAST) ? '0 : to_cnt_q + TO_W'(1);
        end
        timeout_expire = (state_q != RUN) && i_tick_100hz && !any_btn && (to_cnt_q == TO_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    // Without auto-exit the set states never time out.
    assign timeout_expire = (TIMEOUT_TICKS < 0);
`endif

    always_comb begin
        state_d    = state_q;
        clr_msec_d = 1'b0;
        inc_hour_d = 1'b0;
        inc_min_d  = 1'b0;
        inc_sec_d  = 1'b0;
        blink_clr  = 1'b0;
        if (state_q == RUN) begin
            if (btn_mode) begin
                state_d    = SET_HOUR;
                clr_msec_d = 1'b1;
            end
        end else if (btn_mode || timeout_expire) begin
            state_d = RUN;
        end else if (btn_next) begin
            state_d = next_field(state_q);
        end else if (btn_up) begin
            blink_clr  = 1'b1;
            inc_hour_d = (state_q == SET_HOUR);
            inc_min_d  = (state_q == SET_MIN);
            inc_sec_d  = (state_q == SET_SEC);
        end
        blink_clr = blink_clr | (state_d != state_q);
        run_d     = (state_d == RUN);
        sel_d     = sel_code(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            run_q      <= 1'b1;
            sel_q      <= SEL_NONE;
            clr_msec_q <= 1'b0;
            inc_hour_q <= 1'b0;
            inc_min_q  <= 1'b0;
            inc_sec_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            sel_q      <= sel_d;
            clr_msec_q <= clr_msec_d;
            inc_hour_q <= inc_hour_d;
            inc_min_q  <= inc_min_d;
            inc_sec_q  <= inc_sec_d;
        end
    end

    clock_set_blink #(
        .BLINK_TICKS(BLINK_TICKS)
    ) u_blink (
        .clk    (clk),
        .rst    (rst),
        .i_en   (state_q != RUN),
        .i_tick (i_tick_100hz),
        .i_clr  (blink_clr),
        .o_blink(o_blink)
    );

    assign o_run      = run_q;
    assign o_sel      = sel_q;
    assign o_clr_msec = clr_msec_q;
    assign o_inc_hour = inc_hour_q;
    assign o_inc_min  = inc_min_q;
    assign o_inc_sec  = inc_sec_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus random buttons against a field-level model.
module tb_clock_set_ctrl;

    localparam int BT = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_tick_100hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_up = 1'b0;
    logic       o_run, o_clr_msec, o_inc_hour, o_inc_min, o_inc_sec, o_blink;
    logic [1:0] o_sel;

    int checks = 0;
    int errors = 0;

    // Model: selected field (0 none, 1 hour, 2 min, 3 sec), ticks since last edit, idle ticks.
    int         m_field, m_prev, m_ticks, m_idle;
    bit         m_any, m_edit, m_expire;
    logic       e_run, e_clr, e_ih, e_im, e_is, e_blink;
    logic [1:0] e_sel;

    clock_set_ctrl #(
        .BLINK_TICKS  (BT),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_tick_100hz(i_tick_100hz),
        .btn_mode    (btn_mode),
        .btn_next    (btn_next),
        .btn_up      (btn_up),
        .o_run       (o_run),
        .o_clr_msec  (o_clr_msec),
        .o_inc_hour  (o_inc_hour),
        .o_inc_min   (o_inc_min),
        .o_inc_sec   (o_inc_sec),
        .o_sel       (o_sel),
        .o_blink     (o_blink)
    );

    always #5 clk = ~clk;

    // Blink phase is simply (ticks since the last edit / BT) mod 2.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_field = 0; m_ticks = 0; m_idle = 0;
            e_run = 1'b1; e_sel = 2'd0; e_clr = 1'b0;
            e_ih = 1'b0; e_im = 1'b0; e_is = 1'b0; e_blink = 1'b0;
        end else begin
            m_prev = m_field; m_edit = 0; m_expire = 0;
            m_any = btn_mode | btn_next | btn_up;
            e_clr = 1'b0; e_ih = 1'b0; e_im = 1'b0; e_is = 1'b0;
            if (m_field == 0) begin
                if (btn_mode) begin
                    m_field = 1;
                    e_clr = 1'b1;
                end
            end else begin
`ifdef CLOCK_SET_CTRL_AUTO_EXIT_EN
                m_expire = i_tick_100hz && !m_any && (m_idle == TO - 1);
`endif
                if (btn_mode || m_expire) begin
                    m_field = 0;
                end else if (btn_next) begin
                    m_field = m_field % 3 + 1;
                end else if (btn_up) begin
                    m_edit = 1;
                    e_ih = (m_field == 1);
                    e_im = (m_field == 2);
                    e_is = (m_field == 3);
                end
            end
            if (m_prev == 0 || m_any || m_expire) m_idle = 0;
            else if (i_tick_100hz) m_idle++;
            if (m_prev == 0 || m_field != m_prev || m_edit) m_ticks = 0;
            else if (i_tick_100hz) m_ticks++;
            e_run   = (m_field == 0);
            e_sel   = 2'(m_field);
            e_blink = (m_field != 0) && ((m_ticks / BT) % 2 == 1);
        end
    end

    task automatic check_value(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput();
        check_value("run", 2'(o_run), 2'(e_run));
        check_value("sel", o_sel, e_sel);
        check_value("clr_msec", 2'(o_clr_msec), 2'(e_clr));
        check_value("inc_hour", 2'(o_inc_hour), 2'(e_ih));
        check_value("inc_min", 2'(o_inc_min), 2'(e_im));
        check_value("inc_sec", 2'(o_inc_sec), 2'(e_is));
        check_value("blink", 2'(o_blink), 2'(e_blink));
        check_value("no_inc_in_run", 2'(o_run & (o_inc_hour | o_inc_min | o_inc_sec)), 2'd0);
    endtask

    // Drive one cycle of inputs at a falling edge, then compare after the next rising edge.
    task automatic applyStimulus(input logic m, input logic n, input logic u, input logic t);
        btn_mode = m; btn_next = n; btn_up = u; i_tick_100hz = t;
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput();
        check_value("reset_run", 2'(o_run), 2'd1);
        check_value("reset_sel", o_sel, 2'd0);
        check_value("reset_blink", 2'(o_blink), 2'd0);

        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_value("idle_run", 2'(o_run), 2'd1);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        check_value("enter_run", 2'(o_run), 2'd0);
        check_value("enter_sel", o_sel, 2'd1);
        check_value("enter_clr", 2'(o_clr_msec), 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_value("clr_one_cycle", 2'(o_clr_msec), 2'd0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            check_value("up_hour_pulse", 2'(o_inc_hour), 2'd1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            check_value("up_hour_low", 2'(o_inc_hour), 2'd0);
        end

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_value("next_sel_min", o_sel, 2'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_value("next_sel_sec", o_sel, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check_value("up_sec", 2'(o_inc_sec), 2'd1);
        check_value("up_sec_hour", 2'(o_inc_hour), 2'd0);
        check_value("up_sec_min", 2'(o_inc_min), 2'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_value("next_sel_wrap", o_sel, 2'd1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        check_value("prio_run", 2'(o_run), 2'd1);
        check_value("prio_sel", o_sel, 2'd0);
        check_value("prio_no_inc", 2'(o_inc_hour | o_inc_min | o_inc_sec), 2'd0);

        // Blink: tick every third cycle, four ticks per half-period.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 18; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'(k % 3 == 2));
            if (k == 10) check_value("blink_before", 2'(o_blink), 2'd0);
            if (k == 11) check_value("blink_rise", 2'(o_blink), 2'd1);
        end
        check_value("blink_mid", 2'(o_blink), 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check_value("blink_up_clear", 2'(o_blink), 2'd0);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'(k % 3 == 2));
            if (k == 10) check_value("blink_restart_before", 2'(o_blink), 2'd0);
            if (k == 11) check_value("blink_restart_rise", 2'(o_blink), 2'd1);
        end

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef CLOCK_SET_CTRL_AUTO_EXIT_EN
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 7) check_value("timeout_hold", o_sel, 2'd3);
            if (i == 8) check_value("timeout_exit", 2'(o_run), 2'd1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 13; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 12) check_value("timeout_restart_hold", 2'(o_run), 2'd0);
            if (i == 13) check_value("timeout_restart_exit", 2'(o_run), 2'd1);
        end
`else
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_value("set_persists", o_sel, 2'd3);
`endif

        // Asynchronous reset while a pulse is on the outputs.
        if (o_run) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_value("async_rst_run", 2'(o_run), 2'd1);
        check_value("async_rst_sel", o_sel, 2'd0);
        check_value("async_rst_inc", 2'(o_inc_hour | o_inc_min | o_inc_sec), 2'd0);
        #1 rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            applyStimulus(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Control unit for the 24-h clock datapath (msec/sec/min/hour counter chain with a 100 Hz divider).
- Sequences a time-setting mode: the user enters set mode, selects a field and increments it.
- While setting, the block freezes counting and issues one-cycle increment pulses to the selected counter.
- Drives blink control for the FND display so the selected field flashes.

Parameters:
- BLINK_TICKS, 50, number of 100 Hz ticks per blink half-period (50 gives 1 Hz blink).
- TIMEOUT_TICKS, 1000, idle 100 Hz ticks before auto-exit to RUN (used only with the optional feature).

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  asynchronous reset, active-high
- i_tick_100hz  input  1  one-cycle 100 Hz tick from the datapath divider
- btn_mode  input  1  debounced one-cycle pulse; enters or leaves set mode
- btn_next  input  1  debounced one-cycle pulse; selects the next field
- btn_up  input  1  debounced one-cycle pulse; increments the selected field
- o_run  output  1  1 = datapath counts normally; 0 = counting frozen
- o_clr_msec  output  1  one-cycle pulse that clears the msec counter
- o_inc_hour  output  1  one-cycle increment pulse to the hour counter
- o_inc_min  output  1  one-cycle increment pulse to the min counter
- o_inc_sec  output  1  one-cycle increment pulse to the sec counter
- o_sel  output  2  selected field: 0 = none, 1 = hour, 2 = min, 3 = sec
- o_blink  output  1  1 = blank the selected field this half-period

Behaviour:
- States: RUN, SET_HOUR, SET_MIN, SET_SEC.
- All outputs are registered.
- Reset values: state RUN, o_run=1, o_sel=0, o_blink=0, all pulses 0, blink counter 0, timeout counter 0.
- RUN + btn_mode -> SET_HOUR. On the next cycle o_run=0, o_sel=1, and o_clr_msec pulses for one cycle.
- SET_x + btn_mode -> RUN. o_run=1 and o_sel=0 on the next cycle; no msec clear.
- btn_next cycles SET_HOUR -> SET_MIN -> SET_SEC -> SET_HOUR. btn_next is ignored in RUN.
- btn_up in SET_x produces a one-cycle o_inc_x exactly 1 cycle later. btn_up is ignored in RUN.
- The block does not wrap field values; the datapath counters wrap themselves (hour 23 -> 0, min/sec 59 -> 0).
- Simultaneous buttons, priority btn_mode > btn_next > btn_up. Lower-priority buttons in the same cycle are dropped: no increment and no field change.
- At most one o_inc_* is high in any cycle; no o_inc_* is ever high while o_run=1.
- Blink:
  - A counter counts i_tick_100hz only in SET states.
  - At BLINK_TICKS-1 it wraps to 0 and toggles o_blink.
  - On any state change or btn_up, the counter clears and o_blink=0, so the field is visible immediately after an edit.
  - In RUN, o_blink=0.
- Reset mid-set: the block returns to RUN at once (async); no pulses are emitted.
- Blink counter width: $clog2(BLINK_TICKS). Timeout counter width: $clog2(TIMEOUT_TICKS).

Optional Feature:
- Macro: CLOCK_SET_CTRL_AUTO_EXIT_EN.
- Defined:
  - A timeout counter counts i_tick_100hz in SET states.
  - Any button pulse clears it.
  - Reaching TIMEOUT_TICKS-1 forces the -> RUN transition; outputs match the btn_mode exit path.
- Undefined: no timeout counter is instantiated, and SET states persist indefinitely.

Decomposition:
- Shared package clock_pkg:
  - state encoding localparams (RUN=2'd0, SET_HOUR=2'd1, SET_MIN=2'd2, SET_SEC=2'd3);
  - o_sel field codes;
  - default BLINK_TICKS and TIMEOUT_TICKS.
- One sub-module, clock_set_blink: tick-driven blink counter with a synchronous clear input, producing o_blink.
- The FSM and pulse generation stay in the top module.

Test Plan:
- Reset release -> o_run=1, o_sel=0, o_blink=0, all pulses 0; state RUN held for 10 cycles with no buttons.
- btn_mode at cycle 5 -> cycle 6: o_run=0, o_sel=1, o_clr_msec=1 for exactly 1 cycle; then btn_up x3 -> three single-cycle o_inc_hour pulses, each 1 cycle after its btn_up.
- In SET_HOUR: btn_next x3 -> o_sel sequence 2, 3, 1. btn_up in SET_SEC -> o_inc_sec only, with o_inc_hour and o_inc_min staying 0.
- In SET_MIN: btn_mode, btn_next and btn_up together in one cycle -> state RUN, o_run=1, o_sel=0, no o_inc_* pulse.
- Blink with BLINK_TICKS=4 and i_tick_100hz every 3 cycles:
  - o_blink toggles every 12 cycles;
  - btn_up mid-period forces o_blink=0 and restarts the 12-cycle period.
- With CLOCK_SET_CTRL_AUTO_EXIT_EN and TIMEOUT_TICKS=8: 8 idle ticks in SET_SEC -> RUN, o_run=1. A btn_up at tick 5 restarts the count, so the exit occurs at tick 13.
